// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// fifo_pkg : Gray/binary helpers and shared types for the async FIFO controllers
// Rev 1.0
// ============================================================================
package fifo_pkg;

  localparam int FIFO_ASIZE = 4;
  localparam int c_FUNC_W   = 32;

  typedef logic [FIFO_ASIZE:0] ptr_t;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ostage_e;

  // Any width up to c_FUNC_W: zero-extend on the way in, size-cast on the way out.
  function automatic logic [c_FUNC_W-1:0] bin2gray(input logic [c_FUNC_W-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [c_FUNC_W-1:0] gray2bin(input logic [c_FUNC_W-1:0] g);
    logic [c_FUNC_W-1:0] b;
    b[c_FUNC_W-1] = g[c_FUNC_W-1];
    for (int i = c_FUNC_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_ctrl_if.sv
`default_nettype none
// ============================================================================
// fifo_rd_ctrl_if : read-domain bus of the async FIFO (pointers, memory, output stage)
// Rev 1.0
// ============================================================================
interface fifo_rd_ctrl_if
  import fifo_pkg::*;
#(
  parameter int ASIZE = FIFO_ASIZE,
  parameter int DSIZE = 8
);

  logic [ASIZE:0]   rq2_wptr;
  logic [ASIZE:0]   rptr;
  logic [ASIZE-1:0] raddr;
  logic [DSIZE-1:0] rdata_mem;
  logic [DSIZE-1:0] rdata;
  logic             rvalid;
  logic             rready;
  logic             rempty;
  logic [ASIZE:0]   rlevel;
  logic             ralmost_empty;

  modport master (
    input  rq2_wptr, rdata_mem, rready,
    output rptr, raddr, rdata, rvalid, rempty, rlevel, ralmost_empty
  );

  modport slave (
    output rq2_wptr, rdata_mem, rready,
    input  rptr, raddr, rdata, rvalid, rempty, rlevel, ralmost_empty
  );

endinterface
`default_nettype wire

// File: rtl/fifo_gray_ptr.sv
`default_nettype none
// ============================================================================
// fifo_gray_ptr : binary + Gray pointer register, shared by read and write sides
// Rev 1.0
// ============================================================================
module fifo_gray_ptr
  import fifo_pkg::*;
#(
  parameter int ASIZE = FIFO_ASIZE
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  input  wire logic           inc_i,
  output logic [ASIZE:0]      rbin_o,
  output logic [ASIZE:0]      rbinnext_o,
  output logic [ASIZE:0]      rgraynext_o,
  output logic [ASIZE:0]      rptr_o
);

  logic [ASIZE:0] bin_q;
  logic [ASIZE:0] gray_q;

  assign rbinnext_o  = bin_q + {{ASIZE{1'b0}}, inc_i};
  assign rgraynext_o = (ASIZE+1)'(bin2gray(c_FUNC_W'(rbinnext_o)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
    end else begin
      bin_q  <= rbinnext_o;
      gray_q <= rgraynext_o;
    end
  end

  assign rbin_o = bin_q;
  assign rptr_o = gray_q;

endmodule
`default_nettype wire

// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// fifo_rd_ctrl : async FIFO read-domain controller with registered valid/ready stage
// Optional level outputs: define FIFO_RD_LEVEL_EN.  Rev 1.0
// ============================================================================
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ASIZE     = FIFO_ASIZE,
  parameter int DSIZE     = 8,
  parameter int AE_THRESH = 2
) (
  input  wire logic      rclk,
  input  wire logic      rrst_n,
  fifo_rd_ctrl_if.master bus
);

  logic             rinc;
  logic             rvalid;
  logic             rempty_q;
  logic [DSIZE-1:0] rdata_q;
  logic [ASIZE:0]   rbin;
  logic [ASIZE:0]   rbinnext;
  logic [ASIZE:0]   rgraynext;
  logic [ASIZE:0]   rptr;
  ostage_e          state_q;
  ostage_e          state_d;

  // Pop whenever memory has a word and the stage is free or being drained.
  assign rinc = !rempty_q && (!rvalid || bus.rready);

  fifo_gray_ptr #(
    .ASIZE (ASIZE)
  ) u_rptr (
    .clk         (rclk),
    .rst_n       (rrst_n),
    .inc_i       (rinc),
    .rbin_o      (rbin),
    .rbinnext_o  (rbinnext),
    .rgraynext_o (rgraynext),
    .rptr_o      (rptr)
  );

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (rinc) state_d = FULL;
      FULL:    if (bus.rready && !rinc) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    rvalid = 1'b0;
    if (state_q == FULL) rvalid = 1'b1;
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rempty_q <= 1'b1;
      rdata_q  <= '0;
    end else begin
      rempty_q <= (rgraynext == bus.rq2_wptr);
      if (rinc) rdata_q <= bus.rdata_mem;
    end
  end

  assign bus.rptr   = rptr;
  assign bus.raddr  = rbin[ASIZE-1:0];
  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid;
  assign bus.rempty = rempty_q;

`ifdef FIFO_RD_LEVEL_EN
  logic [ASIZE:0] wbin;
  logic [ASIZE:0] level_d;
  logic [ASIZE:0] level_q;
  logic           ae_q;
  logic           unused_rbin_msb;

  // Modulo subtraction stays exact because the read side never sees more than 2**ASIZE words.
  assign wbin    = (ASIZE+1)'(gray2bin(c_FUNC_W'(bus.rq2_wptr)));
  assign level_d = wbin - rbinnext;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      level_q <= '0;
      ae_q    <= 1'b1;
    end else begin
      level_q <= level_d;
      ae_q    <= (level_d <= (ASIZE+1)'(AE_THRESH));
    end
  end

  assign bus.rlevel        = level_q;
  assign bus.ralmost_empty = ae_q;
  assign unused_rbin_msb   = rbin[ASIZE];
`else
  logic [ASIZE+33:0] unused_bits;

  assign bus.rlevel        = '0;
  assign bus.ralmost_empty = rempty_q;
  assign unused_bits       = {rbin[ASIZE], rbinnext, 32'(AE_THRESH)};
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
`default_nettype none
// tb_fifo_rd_ctrl : directed scoreboard bench for the async FIFO read controller.
module tb_fifo_rd_ctrl;
  import fifo_pkg::*;

  localparam int ASIZE     = 4;
  localparam int DSIZE     = 8;
  localparam int AE_THRESH = 2;

  logic rclk   = 1'b0;
  logic rrst_n = 1'b0;
  always #5 rclk = ~rclk;

  fifo_rd_ctrl_if #(.ASIZE(ASIZE), .DSIZE(DSIZE)) bus ();

  fifo_rd_ctrl #(
    .ASIZE     (ASIZE),
    .DSIZE     (DSIZE),
    .AE_THRESH (AE_THRESH)
  ) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .bus    (bus)
  );

  logic [DSIZE-1:0] mem [16];
  assign bus.rdata_mem = mem[bus.raddr];

  logic [DSIZE-1:0] sb [$];
  int n_checks = 0;
  int n_errors = 0;
  int wbin     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic ptr_t gray(input int b);
    ptr_t v;
    v = ptr_t'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic logic [31:0] exp_lvl(input int n);
`ifdef FIFO_RD_LEVEL_EN
    return 32'(n);
`else
    return 32'd0 & 32'(n);
`endif
  endfunction

  function automatic logic [31:0] exp_ae(input int n, input logic empty);
`ifdef FIFO_RD_LEVEL_EN
    return {31'd0, (n <= AE_THRESH)} | {31'd0, empty & 1'b0};
`else
    return {31'd0, empty} | {31'd0, (n < 0)};
`endif
  endfunction

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic do_reset();
    chk("sb_drained", sb.size(), 0);
    rrst_n         = 1'b0;
    bus.rready     = 1'b0;
    bus.rq2_wptr   = '0;
    wbin           = 0;
    tick();
    tick();
    rrst_n = 1'b1;
  endtask

  // Write side model: fill memory, queue the expected words, publish new pointer.
  task automatic write_words(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      mem[(wbin + i) % 16] = DSIZE'(base + i);
      sb.push_back(DSIZE'(base + i));
    end
    wbin         = (wbin + n) % 32;
    bus.rq2_wptr = gray(wbin);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    tick();
    while (!(bus.rempty && !bus.rvalid) && k < 64) begin
      tick();
      k++;
    end
    chk(name, 32'(k < 64), 1);
  endtask

  // Scoreboard monitor: a handshake completes at the next rising edge.
  always @(negedge rclk) begin
    logic [DSIZE-1:0] e;
    if (rrst_n && bus.rvalid && bus.rready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL pop_unexpected: got 0x%0h expected no word", bus.rdata);
      end else begin
        e = sb.pop_front();
        chk("pop_data", bus.rdata, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    bus.rready   = 1'b0;
    bus.rq2_wptr = '0;
    tick();
    tick();

    // Reset state
    chk("rst_rptr",   bus.rptr, 0);
    chk("rst_raddr",  bus.raddr, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_rdata",  bus.rdata, 0);
    chk("rst_rempty", bus.rempty, 1);
    chk("rst_rlevel", bus.rlevel, 0);
    chk("rst_ae",     bus.ralmost_empty, 1);
    rrst_n = 1'b1;
    tick();
    chk("rst_rempty_rel", bus.rempty, 1);

    // Single word, held under rready=0
    write_words(1, 'hA5);
    tick();
    chk("s2_rempty_fall", bus.rempty, 0);
    chk("s2_rvalid_lat",  bus.rvalid, 0);
    chk("s2_rlevel",      bus.rlevel, exp_lvl(1));
    tick();
    chk("s2_rvalid",      bus.rvalid, 1);
    chk("s2_rdata",       bus.rdata, 'hA5);
    chk("s2_rptr",        bus.rptr, 5'b00001);
    chk("s2_rempty_back", bus.rempty, 1);
    chk("s2_raddr",       bus.raddr, 1);
    repeat (3) tick();
    chk("s2_hold_rvalid", bus.rvalid, 1);
    chk("s2_hold_rdata",  bus.rdata, 'hA5);
    bus.rready = 1'b1;
    tick();
    chk("s2_consumed",    bus.rvalid, 0);
    chk("s2_rdata_kept",  bus.rdata, 'hA5);

    // Full 16-word stream, no bubbles
    do_reset();
    bus.rready = 1'b1;
    write_words(16, 'h40);
    tick();
    chk("s3_rempty",  bus.rempty, 0);
    chk("s3_rlevel",  bus.rlevel, exp_lvl(16));
    chk("s3_raddr0",  bus.raddr, 0);
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("s3_rvalid_%0d", k), bus.rvalid, 1);
      chk($sformatf("s3_raddr_%0d", k),  bus.raddr, (k + 1) % 16);
    end
    chk("s3_rptr_end",   bus.rptr, 5'b11000);
    chk("s3_rempty_end", bus.rempty, 1);
    chk("s3_rlevel_end", bus.rlevel, exp_lvl(0));
    chk("s3_ae_end",     bus.ralmost_empty, exp_ae(0, 1'b1));
    tick();
    chk("s3_rvalid_off", bus.rvalid, 0);

    // Backpressure with three words; level 3 -> 2 crosses the threshold
    do_reset();
    write_words(3, 'h31);
    tick();
    chk("s4_rlevel3", bus.rlevel, exp_lvl(3));
    chk("s4_ae3",     bus.ralmost_empty, exp_ae(3, 1'b0));
    tick();
    chk("s4_rvalid",  bus.rvalid, 1);
    chk("s4_rdata",   bus.rdata, 'h31);
    repeat (3) tick();
    chk("s4_rdata_stable", bus.rdata, 'h31);
    chk("s4_one_pop",      bus.rptr, gray(1));
    chk("s4_rlevel2",      bus.rlevel, exp_lvl(2));
    chk("s4_ae2",          bus.ralmost_empty, exp_ae(2, 1'b0));
    chk("s4_rempty",       bus.rempty, 0);
    bus.rready = 1'b1;
    tick();
    chk("s4_b2b_valid1", bus.rvalid, 1);
    chk("s4_b2b_data1",  bus.rdata, 'h32);
    tick();
    chk("s4_b2b_valid2", bus.rvalid, 1);
    chk("s4_b2b_data2",  bus.rdata, 'h33);
    chk("s4_rempty_end", bus.rempty, 1);
    tick();
    chk("s4_rvalid_off", bus.rvalid, 0);

    // Wrap-around of address and pointer MSB
    do_reset();
    bus.rready = 1'b1;
    write_words(16, 'h60);
    drain("s5_drain_a");
    write_words(14, 'h80);
    drain("s5_drain_b");
    chk("s5_raddr30", bus.raddr, 14);
    chk("s5_rptr30",  bus.rptr, 5'b10001);
    write_words(3, 'hC0);
    chk("s5_wptr", bus.rq2_wptr, 5'b00001);
    tick();
    chk("s5_w0_raddr",  bus.raddr, 14);
    chk("s5_w0_rptr",   bus.rptr, 5'b10001);
    chk("s5_w0_rempty", bus.rempty, 0);
    tick();
    chk("s5_w1_raddr", bus.raddr, 15);
    chk("s5_w1_rptr",  bus.rptr, 5'b10000);
    tick();
    chk("s5_w2_raddr", bus.raddr, 0);
    chk("s5_w2_rptr",  bus.rptr, 5'b00000);
    tick();
    chk("s5_w3_raddr",  bus.raddr, 1);
    chk("s5_w3_rptr",   bus.rptr, 5'b00001);
    chk("s5_w3_rempty", bus.rempty, 1);
    drain("s5_drain_c");

    // Asynchronous reset with a word in the stage
    do_reset();
    write_words(2, 'hE0);
    tick();
    tick();
    chk("s7_rvalid", bus.rvalid, 1);
    #2;
    rrst_n = 1'b0;
    #1;
    chk("s7_async_rvalid", bus.rvalid, 0);
    chk("s7_async_rempty", bus.rempty, 1);
    chk("s7_async_rptr",   bus.rptr, 0);
    chk("s7_async_rdata",  bus.rdata, 0);
    sb.delete();
    bus.rq2_wptr = '0;
    wbin         = 0;
    tick();
    rrst_n = 1'b1;
    tick();
    chk("s7_post_rempty", bus.rempty, 1);
    chk("s7_post_rvalid", bus.rvalid, 0);

    chk("sb_final", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-domain controller of the async FIFO. It consumes the write pointer after it has been synchronized into rclk, advances the binary/Gray read pointer, and addresses the asynchronous-read FIFO memory. It presents popped words on a registered valid/ready output stage and returns the Gray read pointer for synchronization into the write domain.

## Interface
- ASIZE, 4, address width; FIFO depth 2**ASIZE; pointers ASIZE+1 bits.
- DSIZE, 8, data width.
- AE_THRESH, 2, almost-empty threshold in words; range 0..2**ASIZE.

Ports:
- rclk  in  1  read clock
- rrst_n  in  1  reset, asynchronous, active-low
- rq2_wptr  in  ASIZE+1  Gray write pointer, already synchronized to rclk
- rptr  out  ASIZE+1  Gray read pointer, registered, to the write-domain synchronizer
- raddr  out  ASIZE  memory read address, equal to rbin[ASIZE-1:0]
- rdata_mem  in  DSIZE  memory read data, combinational from raddr
- rdata  out  DSIZE  output-stage data
- rvalid  out  1  rdata holds a word
- rready  in  1  consumer accepts rdata this cycle
- rempty  out  1  memory holds no unread word (output stage excluded)
- rlevel  out  ASIZE+1  words in memory, 0..2**ASIZE
- ralmost_empty  out  1  rlevel <= AE_THRESH

## Operation
- rbin (ASIZE+1, binary) and rptr (Gray) are registered.
- rinc = !rempty && (!rvalid || rready).
- rbinnext = rbin + rinc, wrapping modulo 2**(ASIZE+1). rgraynext = (rbinnext>>1) ^ rbinnext.
- rempty <= (rgraynext == rq2_wptr).
- Output stage has two states, EMPTY (rvalid=0) and FULL (rvalid=1):
  - EMPTY -> FULL on rinc.
  - FULL -> EMPTY on rready && !rinc.
  - FULL stays FULL on rready && rinc (pass-through, one word per cycle) or on !rready (hold).
- rdata loads rdata_mem only on rinc. Otherwise rdata holds its value. rdata is unchanged after consumption.
- rlevel <= gray2bin(rq2_wptr) - rbinnext, computed at ASIZE+1 width, modulo arithmetic.
- ralmost_empty <= (that difference <= AE_THRESH).
- rq2_wptr is trusted to be a legal Gray value, one step per change at most. The block does no checking.
- Full condition is owned by the write side. The read side never observes more than 2**ASIZE words.

## Timing
- Reset values: rptr=0, rbin=0, raddr=0, rdata=0, rvalid=0, rempty=1, rlevel=0, ralmost_empty=1.
- New rq2_wptr value in cycle N:
  - rempty falls at edge N+1.
  - rinc occurs in cycle N+1.
  - rvalid rises at edge N+2.
- With rready held high and the FIFO non-empty, one word is delivered per cycle with no bubbles.
- rptr advances on the same edge that loads rdata.
- rempty and rlevel reflect the post-pop pointer at that edge.
- Wrap-around: raddr wraps 2**ASIZE-1 -> 0. The pointer MSB toggles and the Gray comparison remains exact.
- Assertion of rrst_n mid-transfer clears all state immediately; any in-stage word is lost. The write domain is reset in the same reset event.
- rready while rvalid=0 is ignored.

## Configuration
- FIFO_RD_LEVEL_EN defined: rlevel and ralmost_empty behave as specified above.
- FIFO_RD_LEVEL_EN undefined:
  - rlevel is tied to 0.
  - ralmost_empty equals rempty.
  - The gray2bin and subtract logic is removed.
- AE_THRESH is ignored when the macro is undefined.

## Structure
- fifo_pkg holds:
  - bin2gray and gray2bin functions, parameterized by width.
  - typedef ptr_t for the ASIZE+1 pointer.
  - typedef enum of the output-stage states EMPTY and FULL.
- fifo_pkg is shared with the write-side controller.
- One sub-module, fifo_gray_ptr: binary+Gray pointer register with an inc input and rbin/rbinnext/rgraynext/rptr outputs. It is reused by the write side.

## Test plan
All scenarios use ASIZE=4, DSIZE=8, AE_THRESH=2.
1. Reset with rq2_wptr=0 -> rptr=0, raddr=0, rvalid=0, rdata=0, rempty=1, rlevel=0, ralmost_empty=1.
2. Single word: mem[0]=0xA5, rq2_wptr=5'b00001, rready=0.
   - rempty falls 1 cycle later.
   - rvalid=1 and rdata=0xA5 2 cycles after the wptr change.
   - rptr=5'b00001, rempty=1 again, rvalid held until rready.
3. Full stream: rq2_wptr=gray(16)=5'b11000, rready=1 -> 16 consecutive words for raddr 0..15, no bubbles; final rptr=5'b11000, rempty=1, rlevel 16->0.
4. Backpressure: 3 words written, rready=0.
   - Exactly one pop; rdata is stable.
   - rlevel=2, ralmost_empty=1.
   - Raising rready drains the remaining 2 words back-to-back.
5. Wrap: pop until rbin=30, then rq2_wptr=gray(1)=5'b00001.
   - raddr sequence 14, 15, 0.
   - rptr sequence 10001, 10000, 00000, 00001; then rempty=1.
6. Macro: with FIFO_RD_LEVEL_EN, level 3->2 asserts ralmost_empty. Without it, rlevel stays 0 and ralmost_empty tracks rempty.
